// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - intc register map and controller state encoding
package intc_pkg;

    localparam logic [31:0] INTC_PEND_ADDR  = 32'h0000_2000;
    localparam logic [31:0] INTC_MASK_ADDR  = 32'h0000_2008;
    localparam logic [31:0] INTC_CLAIM_ADDR = 32'h0000_2010;

    typedef enum logic [1:0] {
        INTC_IDLE    = 2'd0,
        INTC_REQ     = 2'd1,
        INTC_SERVICE = 2'd2
    } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - lowest-set-bit priority encoder for intc claims
module intc_prio_enc #(
    parameter int sources   = 8,
    parameter int idx_width = (sources > 1) ? $clog2(sources) : 1
) (
    input  logic [sources-1:0]   req,
    output logic                 valid,
    output logic [idx_width-1:0] idx
);

    // Scan downwards so the last hit is the lowest-numbered request.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = sources - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = idx_width'(i);
            end
        end
    end

endmodule

// File: rtl/register.sv
// rtl/register.sv - generic load-enabled flop bank with async active-high reset
module register #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/intc.sv
// rtl/intc.sv - interrupt controller: pending/mask/claim registers and take/eret FSM
// Define INTC_EDGE_EN for rising-edge source detection; default is level-sensitive.
module intc
    import intc_pkg::*;
#(
    parameter int width   = 64,
    parameter int sources = 8
) (
    input  logic               clock,
    input  logic               reset,
    output logic               IntcInterrupt,
    output logic               IntcAddress,
    output logic [width-1:0]   rdata,
    input  logic               enable,
    input  logic [width-1:0]   data,
    input  logic [width-1:0]   address,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [sources-1:0] irq_src,
    input  logic               take,
    input  logic               eret
);

    localparam int IDXW = (sources > 1) ? $clog2(sources) : 1;

    logic               reset_h;
    logic               hit_pend, hit_mask, hit_claim;
    logic [sources-1:0] pend_q, pend_d, mask_q, src_event, active, claim_clr, w1c;
    logic [IDXW-1:0]    claim_idx, in_service_q;
    logic               claim_valid, claim_fire;
    logic [1:0]         state_bits;
    intc_state_t        state_q, state_d;
    logic [width-1:0]   rdata_val;
    logic               unused_ok;

    assign reset_h = ~reset;

    assign hit_pend    = enable && (address == width'(INTC_PEND_ADDR));
    assign hit_mask    = enable && (address == width'(INTC_MASK_ADDR));
    assign hit_claim   = enable && (address == width'(INTC_CLAIM_ADDR));
    assign IntcAddress = hit_pend || hit_mask || hit_claim;

`ifdef INTC_EDGE_EN
    logic [sources-1:0] prev_q;
    register #(.WIDTH(sources)) u_prev (
        .clock(clock), .reset(reset_h), .load(1'b1), .d(irq_src), .q(prev_q)
    );
    assign src_event = irq_src & ~prev_q;
`else
    assign src_event = irq_src;
`endif

    assign active = pend_q & mask_q;

    intc_prio_enc #(.sources(sources), .idx_width(IDXW)) u_prio (
        .req(active), .valid(claim_valid), .idx(claim_idx)
    );

    // Set is OR-ed in last so a new event beats a same-cycle W1C or claim.
    assign claim_fire = hit_claim && MemRead && claim_valid;
    assign claim_clr  = claim_fire ? (sources'(1) << claim_idx) : '0;
    assign w1c        = (hit_pend && MemWrite) ? data[sources-1:0] : '0;
    assign pend_d     = (pend_q & ~(w1c | claim_clr)) | src_event;

    register #(.WIDTH(sources)) u_pend (
        .clock(clock), .reset(reset_h), .load(1'b1), .d(pend_d), .q(pend_q)
    );

    register #(.WIDTH(sources)) u_mask (
        .clock(clock), .reset(reset_h), .load(hit_mask && MemWrite),
        .d(data[sources-1:0]), .q(mask_q)
    );

    register #(.WIDTH(IDXW)) u_in_service (
        .clock(clock), .reset(reset_h), .load(claim_fire), .d(claim_idx), .q(in_service_q)
    );

    register #(.WIDTH(2), .RESET_VALUE(INTC_IDLE)) u_state (
        .clock(clock), .reset(reset_h), .load(1'b1), .d(state_d), .q(state_bits)
    );
    assign state_q = intc_state_t'(state_bits);

    always_comb begin
        state_d       = state_q;
        IntcInterrupt = 1'b0;
        case (state_q)
            INTC_IDLE: begin
                if (|active) state_d = INTC_REQ;
            end
            INTC_REQ: begin
                IntcInterrupt = 1'b1;
                if (take) begin
                    state_d = INTC_SERVICE;
                end else if (!(|active)) begin
                    state_d = INTC_IDLE;
                end
            end
            INTC_SERVICE: begin
                if (eret) state_d = INTC_IDLE;
            end
            default: state_d = INTC_IDLE;
        endcase
    end

    always_comb begin
        rdata_val = '0;
        if (hit_pend) begin
            rdata_val[sources-1:0] = pend_q;
        end else if (hit_mask) begin
            rdata_val[sources-1:0] = mask_q;
        end else if (hit_claim && claim_valid) begin
            rdata_val[width-1]  = 1'b1;
            rdata_val[IDXW-1:0] = claim_idx;
        end
    end

    assign rdata = (IntcAddress && MemRead) ? rdata_val : 'z;

    assign unused_ok = ^{data[width-1:sources], in_service_q};

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - self-checking bench for intc: vector table, directed corners, random vs model
module tb_intc;
    import intc_pkg::*;

    localparam int W = 64;
    localparam int S = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    wire          IntcInterrupt;
    wire          IntcAddress;
    wire  [W-1:0] rdata;
    logic         enable = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] address = '0;
    logic         MemRead = 1'b0;
    logic         MemWrite = 1'b0;
    logic [S-1:0] irq_src = '0;
    logic         take = 1'b0;
    logic         eret = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [W-1:0] A_PEND  = W'(INTC_PEND_ADDR);
    localparam logic [W-1:0] A_MASK  = W'(INTC_MASK_ADDR);
    localparam logic [W-1:0] A_CLAIM = W'(INTC_CLAIM_ADDR);
    localparam logic [W-1:0] A_NONE  = 64'h0000_0000_0000_0040;
    localparam logic [W-1:0] CLAIM_V = 64'h8000_0000_0000_0000;

    intc #(.width(W), .sources(S)) dut (
        .clock(clock), .reset(reset), .IntcInterrupt(IntcInterrupt), .IntcAddress(IntcAddress),
        .rdata(rdata), .enable(enable), .data(data), .address(address), .MemRead(MemRead),
        .MemWrite(MemWrite), .irq_src(irq_src), .take(take), .eret(eret)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rdata;
        bit           exp_hit;
        string        name;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_bus(input string name);
        check(name, W'((rdata === {W{1'bz}}) || (rdata === '0)), W'(1));
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        enable = 0; MemRead = 0; MemWrite = 0; take = 0; eret = 0;
    endtask

    task automatic rd_chk(input logic [W-1:0] a, input logic [W-1:0] exp, input logic exp_irq,
                          input string name);
        enable = 1; MemRead = 1; address = a;
        @(negedge clock);
        check(name, rdata, exp);
        check({name, "_irq"}, W'(IntcInterrupt), W'(exp_irq));
        cyc();
    endtask

    task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d);
        enable = 1; MemWrite = 1; address = a; data = d;
        cyc();
    endtask

    task automatic irq_chk(input logic exp, input string name);
        @(negedge clock);
        check(name, W'(IntcInterrupt), W'(exp));
    endtask

    task automatic do_reset();
        reset = 0; irq_src = '0; enable = 0; MemRead = 0; MemWrite = 0; take = 0; eret = 0;
        @(negedge clock);
        check("reset_irq", W'(IntcInterrupt), '0);
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
    endtask

    function automatic int lowest(input logic [S-1:0] v);
        for (int i = 0; i < S; i++) if (v[i]) return i;
        return -1;
    endfunction

    logic [S-1:0] m_pend, m_mask, m_prev, ev, clr, act;
    bit           m_req, m_busy, hit;
    logic [W-1:0] addrs[4];
    logic [W-1:0] exp_rd;
    int           op;

    initial begin
        vt.push_back('{1, 0, A_PEND,  '0, '0, 1, "rd_pend_rst"});
        vt.push_back('{1, 0, A_MASK,  '0, '0, 1, "rd_mask_rst"});
        vt.push_back('{1, 0, A_CLAIM, '0, '0, 1, "rd_claim_rst"});
        vt.push_back('{1, 0, A_NONE,  '0, '0, 0, "rd_unmapped"});
        vt.push_back('{0, 1, A_MASK,  64'hFF, '0, 1, "wr_mask_ff"});
        vt.push_back('{1, 0, A_MASK,  '0, 64'hFF, 1, "rd_mask_ff"});
        vt.push_back('{0, 1, A_MASK,  64'hFFFF_FFFF_FFFF_FF5A, '0, 1, "wr_mask_wide"});
        vt.push_back('{1, 0, A_MASK,  '0, 64'h5A, 1, "rd_mask_trunc"});
        vt.push_back('{0, 1, A_CLAIM, 64'hFF, '0, 1, "wr_claim"});
        vt.push_back('{1, 0, A_MASK,  '0, 64'h5A, 1, "rd_mask_after_claim_wr"});
        vt.push_back('{1, 0, A_CLAIM, '0, '0, 1, "rd_claim_empty"});
        vt.push_back('{0, 1, A_PEND,  64'hFF, '0, 1, "w1c_empty"});
        vt.push_back('{1, 0, A_PEND,  '0, '0, 1, "rd_pend_after_w1c"});

        do_reset();
        @(negedge clock);
        check_idle_bus("idle_rdata_z");
        check("idle_irq", W'(IntcInterrupt), '0);
        cyc();

        foreach (vt[k]) begin
            enable = 1; MemRead = vt[k].rd; MemWrite = vt[k].wr;
            address = vt[k].addr; data = vt[k].wdata;
            @(negedge clock);
            check({vt[k].name, "_hit"}, W'(IntcAddress), W'(vt[k].exp_hit));
            if (vt[k].rd && vt[k].exp_hit) check(vt[k].name, rdata, vt[k].exp_rdata);
            else if (vt[k].rd) check_idle_bus(vt[k].name);
            cyc();
        end

        // Single-cycle pulse on line 0: pending next cycle, request the cycle after.
        do_reset();
        wr(A_MASK, 64'h01);
        irq_src = 8'h01;
        cyc();
        irq_src = '0;
        rd_chk(A_PEND, 64'h01, 1'b0, "pulse_pend");
        irq_chk(1'b1, "pulse_irq_up");
        take = 1;
        cyc();
        rd_chk(A_CLAIM, CLAIM_V, 1'b0, "pulse_claim");
        rd_chk(A_PEND, '0, 1'b0, "pulse_pend_cleared");

        // Claims return lowest active index, then empty.
        do_reset();
        wr(A_MASK, 64'hFF);
        irq_src = 8'h0C;
        cyc();
        irq_src = '0;
        cyc();
        irq_chk(1'b1, "claim_seq_irq");
        take = 1;
        cyc();
        rd_chk(A_CLAIM, CLAIM_V | 64'h2, 1'b0, "claim_2");
        rd_chk(A_CLAIM, CLAIM_V | 64'h3, 1'b0, "claim_3");
        rd_chk(A_CLAIM, '0, 1'b0, "claim_empty");

        // Masking in REQ withdraws the request.
        do_reset();
        wr(A_MASK, 64'hFF);
        irq_src = 8'h01;
        cyc();
        irq_src = '0;
        cyc();
        irq_chk(1'b1, "req_before_mask");
        wr(A_MASK, 64'h00);
        cyc();
        irq_chk(1'b0, "req_withdrawn");

        // take in the cycle active drops still reaches SERVICE; no nesting there.
        do_reset();
        wr(A_MASK, 64'hFF);
        irq_src = 8'h01;
        cyc();
        irq_src = '0;
        cyc();
        wr(A_MASK, 64'h00);
        take = 1;
        cyc();
        wr(A_MASK, 64'hFF);
        irq_src = 8'h20;
        cyc();
        irq_src = '0;
        irq_chk(1'b0, "service_no_nest_a");
        cyc();
        irq_chk(1'b0, "service_no_nest_b");
        eret = 1;
        cyc();
        irq_chk(1'b0, "eret_plus1");
        cyc();
        irq_chk(1'b1, "eret_plus2");

        // Source held high across a W1C.
        do_reset();
        irq_src = 8'h02;
        repeat (5) cyc();
        wr(A_PEND, 64'h02);
`ifdef INTC_EDGE_EN
        rd_chk(A_PEND, 64'h00, 1'b0, "held_src_w1c");
`else
        rd_chk(A_PEND, 64'h02, 1'b0, "held_src_w1c");
`endif
        repeat (13) cyc();
        irq_src = '0;
        cyc();

        // Read and W1C together return the pre-write value.
        do_reset();
        irq_src = 8'h04;
        cyc();
        irq_src = '0;
        enable = 1; MemRead = 1; MemWrite = 1; address = A_PEND; data = 64'h04;
        @(negedge clock);
        check("rw_same_cycle", rdata, 64'h04);
        cyc();
        rd_chk(A_PEND, '0, 1'b0, "rw_after");

        // Reset while in SERVICE drops everything.
        wr(A_MASK, 64'hFF);
        irq_src = 8'h30;
        cyc();
        irq_src = '0;
        cyc();
        take = 1;
        cyc();
        do_reset();
        rd_chk(A_PEND, '0, 1'b0, "reset_mid_service_pend");
        rd_chk(A_MASK, '0, 1'b0, "reset_mid_service_mask");

        // Randomized traffic against a behavioural model.
        do_reset();
        addrs[0] = A_PEND; addrs[1] = A_MASK; addrs[2] = A_CLAIM; addrs[3] = A_NONE;
        m_pend = '0; m_mask = '0; m_prev = '0; m_req = 0; m_busy = 0;
        for (int n = 0; n < 600; n++) begin
            irq_src  = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
            op       = $urandom_range(0, 5);
            address  = addrs[$urandom_range(0, 3)];
            enable   = (op < 3) ? ($urandom_range(0, 7) != 0) : 1'b0;
            MemRead  = (op == 0) || (op == 2);
            MemWrite = (op == 1) || (op == 2);
            data     = {$urandom, $urandom};
            take     = ($urandom_range(0, 3) == 0);
            eret     = ($urandom_range(0, 3) == 0);
            @(negedge clock);

            act = m_pend & m_mask;
            hit = enable && (address == A_PEND || address == A_MASK || address == A_CLAIM);
            check("rnd_hit", W'(IntcAddress), W'(hit));
            check("rnd_irq", W'(IntcInterrupt), W'(m_req));
            if (hit && MemRead) begin
                if (address == A_PEND) exp_rd = W'(m_pend);
                else if (address == A_MASK) exp_rd = W'(m_mask);
                else exp_rd = (act != 0) ? (CLAIM_V | W'(lowest(act))) : '0;
                check("rnd_rdata", rdata, exp_rd);
            end else begin
                check_idle_bus("rnd_idle_bus");
            end

`ifdef INTC_EDGE_EN
            ev = irq_src & ~m_prev;
`else
            ev = irq_src;
`endif
            m_prev = irq_src;
            clr = '0;
            if (enable && MemWrite && address == A_PEND) clr |= data[S-1:0];
            if (enable && MemRead && address == A_CLAIM && act != 0) clr |= S'(1) << lowest(act);
            if (m_req) begin
                if (take) begin m_req = 0; m_busy = 1; end
                else if (act == 0) m_req = 0;
            end else if (m_busy) begin
                if (eret) m_busy = 0;
            end else if (act != 0) begin
                m_req = 1;
            end
            if (enable && MemWrite && address == A_MASK) m_mask = data[S-1:0];
            m_pend = (m_pend & ~clr) | ev;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
